axis_event_sequencer: RTL and testbench

- Program-driven sequencer feeding the gate controller's TX and RX event streams.
- Fetches 128-bit instruction words from a BRAM program memory and emits TX events (128 bit) and RX events (64 bit) in program order.
- Supports one hardware loop level; the gate controller's tready provides all timing backpressure.
- Sits between the PS-loaded program BRAM and the gate controller's s_axis_tx_evts / s_axis_rx_evts ports.

---
 rtl/axis_event_sequencer_pkg.sv | 31 +++
 rtl/axis_event_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_axis_event_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_event_sequencer_pkg.sv
// rtl/axis_event_sequencer_pkg.sv - opcodes, field positions and state encoding for the event sequencer
package axis_event_sequencer_pkg;

  // Instruction word layout
  localparam int OPC_MSB = 127;
  localparam int OPC_LSB = 124;
  localparam int CNT_MSB = 15;
  localparam int CNT_LSB = 0;
  localparam int TX_PAYLOAD_W = 124;
  localparam int RX_W = 64;

  localparam logic [3:0] OP_HALT    = 4'd0;
  localparam logic [3:0] OP_TX      = 4'd1;
  localparam logic [3:0] OP_RX      = 4'd2;
  localparam logic [3:0] OP_LOOP    = 4'd3;
  localparam logic [3:0] OP_ENDLOOP = 4'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EMIT_TX,
    ST_EMIT_RX
  } state_e;

  // A loop count of zero still runs the body once
  function automatic logic [15:0] loop_count(input logic [15:0] cnt);
    return (cnt == 16'd0) ? 16'd1 : cnt;
  endfunction

endpackage

// File: rtl/axis_event_sequencer.sv
// rtl/axis_event_sequencer.sv - program-driven TX/RX event sequencer with one hardware loop level
module axis_event_sequencer
  import axis_event_sequencer_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] cfg_start_addr,
  output logic [AW-1:0] bram_porta_addr,
  input  logic [127:0]  bram_porta_rddata,
  output logic [127:0]  m_axis_tx_evts_tdata,
  output logic          m_axis_tx_evts_tvalid,
  input  logic          m_axis_tx_evts_tready,
  output logic [63:0]   m_axis_rx_evts_tdata,
  output logic          m_axis_rx_evts_tvalid,
  input  logic          m_axis_rx_evts_tready,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] pc
);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] loop_start_q;
  logic [15:0]   loop_cntr_q;
  logic          loop_active_q;
  logic          stop_pend_q;
  logic [127:0]  tx_tdata_q;
  logic          tx_tvalid_q;
  logic [63:0]   rx_tdata_q;
  logic          rx_tvalid_q;
  logic          busy_q;
  logic          done_q;
  logic          error_q;

  logic [3:0]    op;
  logic [AW-1:0] pc_inc;
  logic          at_end;
  logic          loop_jump;
  logic          decode_fault;
  logic          stop_now;

  assign op        = bram_porta_rddata[OPC_MSB:OPC_LSB];
  assign pc_inc    = pc_q + {{(AW-1){1'b0}}, 1'b1};
  assign at_end    = &pc_q;
  assign loop_jump = (op == OP_ENDLOOP) && loop_active_q && (loop_cntr_q > 16'd1);
  assign stop_now  = stop | stop_pend_q;

  // Nested LOOP, orphan ENDLOOP, and any fall-through past the last word are program faults
  assign decode_fault = ((op == OP_LOOP) && loop_active_q)
                     || ((op == OP_ENDLOOP) && !loop_active_q)
                     || (at_end && (op != OP_HALT) && !loop_jump);

  // Sequencer FSM: fetch/decode, event emission with backpressure, loop bookkeeping
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      pc_q          <= '0;
      loop_start_q  <= '0;
      loop_cntr_q   <= '0;
      loop_active_q <= 1'b0;
      stop_pend_q   <= 1'b0;
      tx_tdata_q    <= '0;
      tx_tvalid_q   <= 1'b0;
      rx_tdata_q    <= '0;
      rx_tvalid_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      if (stop && (state_q != ST_IDLE)) stop_pend_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          stop_pend_q <= 1'b0;
          if (start && !stop) begin
            pc_q          <= cfg_start_addr;
            loop_active_q <= 1'b0;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            state_q       <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (stop_now) begin
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (stop_now) begin
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else if (decode_fault) begin
            error_q <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            case (op)
              OP_HALT: begin
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end
              OP_TX: begin
                tx_tdata_q  <= {4'h0, bram_porta_rddata[TX_PAYLOAD_W-1:0]};
                tx_tvalid_q <= 1'b1;
                state_q     <= ST_EMIT_TX;
              end
              OP_RX: begin
                rx_tdata_q  <= bram_porta_rddata[RX_W-1:0];
                rx_tvalid_q <= 1'b1;
                state_q     <= ST_EMIT_RX;
              end
              OP_LOOP: begin
                loop_cntr_q   <= loop_count(bram_porta_rddata[CNT_MSB:CNT_LSB]);
                loop_active_q <= 1'b1;
                loop_start_q  <= pc_inc;
                pc_q          <= pc_inc;
                state_q       <= ST_FETCH;
              end
              OP_ENDLOOP: begin
                if (loop_jump) begin
                  loop_cntr_q <= loop_cntr_q - 16'd1;
                  pc_q        <= loop_start_q;
                end else begin
                  loop_active_q <= 1'b0;
                  pc_q          <= pc_inc;
                end
                state_q <= ST_FETCH;
              end
              default: begin
                pc_q    <= pc_inc;
                state_q <= ST_FETCH;
              end
            endcase
          end
        end
        ST_EMIT_TX, ST_EMIT_RX: begin
          // The beat in flight always completes; a pending stop is honoured afterwards
          if ((tx_tvalid_q && m_axis_tx_evts_tready) || (rx_tvalid_q && m_axis_rx_evts_tready)) begin
            tx_tvalid_q <= 1'b0;
            rx_tvalid_q <= 1'b0;
            pc_q        <= pc_inc;
            if (stop_now) begin
              stop_pend_q <= 1'b0;
              busy_q      <= 1'b0;
              done_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              state_q <= ST_FETCH;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bram_porta_addr       = pc_q;
  assign pc                    = pc_q;
  assign m_axis_tx_evts_tdata  = tx_tdata_q;
  assign m_axis_tx_evts_tvalid = tx_tvalid_q;
  assign m_axis_rx_evts_tdata  = rx_tdata_q;
  assign m_axis_rx_evts_tvalid = rx_tvalid_q;
  assign busy                  = busy_q;
  assign done                  = done_q;
  assign error                 = error_q;

endmodule

// File: tb/tb_axis_event_sequencer.sv
// tb/tb_axis_event_sequencer.sv - scoreboard bench for axis_event_sequencer
module tb_axis_event_sequencer;

  localparam int AW = 10;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] cfg_start_addr = '0;
  logic [AW-1:0] bram_porta_addr;
  logic [127:0]  bram_porta_rddata = '0;
  logic [127:0]  tx_tdata;
  logic          tx_tvalid;
  logic          tx_tready = 1'b1;
  logic [63:0]   rx_tdata;
  logic          rx_tvalid;
  logic          rx_tready = 1'b1;
  logic          busy, done, error;
  logic [AW-1:0] pc;

  logic [127:0]  mem [0:(1<<AW)-1];

  typedef struct packed {
    logic         is_rx;
    logic [127:0] data;
  } exp_t;
  exp_t exp_q[$];

  int n_run = 0;
  int n_fail = 0;

  axis_event_sequencer #(.AW(AW)) dut (
    .aclk(aclk), .areset(areset), .start(start), .stop(stop),
    .cfg_start_addr(cfg_start_addr),
    .bram_porta_addr(bram_porta_addr), .bram_porta_rddata(bram_porta_rddata),
    .m_axis_tx_evts_tdata(tx_tdata), .m_axis_tx_evts_tvalid(tx_tvalid),
    .m_axis_tx_evts_tready(tx_tready),
    .m_axis_rx_evts_tdata(rx_tdata), .m_axis_rx_evts_tvalid(rx_tvalid),
    .m_axis_rx_evts_tready(rx_tready),
    .busy(busy), .done(done), .error(error), .pc(pc)
  );

  always #5 aclk = ~aclk;

  // Program BRAM with one cycle read latency
  always @(posedge aclk) bram_porta_rddata <= mem[bram_porta_addr];

  function automatic logic [127:0] mk(input logic [3:0] op, input logic [123:0] pl);
    return {op, pl};
  endfunction

  function automatic logic [127:0] tx_exp(input logic [127:0] w);
    return {4'h0, w[123:0]};
  endfunction

  task automatic push_tx(input logic [127:0] w);
    exp_t e;
    e.is_rx = 1'b0;
    e.data  = tx_exp(w);
    exp_q.push_back(e);
  endtask

  task automatic push_rx(input logic [127:0] w);
    exp_t e;
    e.is_rx = 1'b1;
    e.data  = {64'h0, w[63:0]};
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_run++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic check_beat(input logic is_rx, input logic [127:0] data);
    exp_t e;
    n_run++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_beat: got rx=%0b data=%h expected no beat", is_rx, data);
    end else begin
      e = exp_q.pop_front();
      if (e.is_rx !== is_rx || e.data !== data) begin
        n_fail++;
        $display("FAIL beat: got rx=%0b data=%h expected rx=%0b data=%h", is_rx, data, e.is_rx, e.data);
      end
    end
  endtask

  // Monitor: pops the scoreboard on each handshake, sampled mid-cycle
  always @(negedge aclk) begin
    if (!areset) begin
      if (tx_tvalid && rx_tvalid) begin
        n_run++;
        n_fail++;
        $display("FAIL both_valid: got tx=1 rx=1 expected one at most");
      end
      if (tx_tvalid && tx_tready) check_beat(1'b0, tx_tdata);
      if (rx_tvalid && rx_tready) check_beat(1'b1, {64'h0, rx_tdata});
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic pulse_start(input logic [AW-1:0] addr);
    cfg_start_addr = addr;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 2000 && busy; i++) tick();
    if (busy) begin
      n_run++;
      n_fail++;
      $display("FAIL %s_timeout: got busy=1 expected busy=0", name);
    end
  endtask

  task automatic wait_valid(input string name, input logic rx);
    int i;
    for (i = 0; i < 200 && !(rx ? rx_tvalid : tx_tvalid); i++) tick();
    if (!(rx ? rx_tvalid : tx_tvalid)) begin
      n_run++;
      n_fail++;
      $display("FAIL %s_timeout: got tvalid=0 expected tvalid=1", name);
    end
  endtask

  logic [127:0] w_tx_a, w_rx_b, w_tx1, w_rx2, w_tx3, w_rx4, w_tx55, w_rx66;
  logic [127:0] w_tx77, w_rx88, w_rx1234, w_tx42;
  logic [127:0] d0;
  logic [AW-1:0] p0;
  logic stable;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    w_tx_a   = mk(4'd1, 124'hA);
    w_rx_b   = mk(4'd2, {60'hBAD, 64'hB});
    w_tx1    = mk(4'd1, 124'h1);
    w_rx2    = mk(4'd2, 124'h2);
    w_tx3    = mk(4'd1, {4'hF, 120'h3});
    w_rx4    = mk(4'd2, {60'hFFF, 64'h4});
    w_tx55   = mk(4'd1, {4'hC, 120'h55});
    w_rx66   = mk(4'd2, 124'h66);
    w_tx77   = mk(4'd1, 124'h77);
    w_rx88   = mk(4'd2, 124'h88);
    w_rx1234 = mk(4'd2, 124'h1234);
    w_tx42   = mk(4'd1, 124'h42);

    mem[0] = w_tx_a; mem[1] = w_rx_b; mem[2] = '0;
    mem[5] = mk(4'd4, '0); mem[6] = w_tx1;
    mem[16] = mk(4'd3, 124'd3); mem[17] = w_tx1; mem[18] = w_rx2;
    mem[19] = mk(4'd4, '0); mem[20] = '0;
    mem[32] = mk(4'd3, 124'd0); mem[33] = w_tx3; mem[34] = w_rx4;
    mem[35] = mk(4'd4, '0); mem[36] = '0;
    mem[48] = w_tx55; mem[49] = w_rx66; mem[50] = '0;
    mem[64] = w_tx77; mem[65] = w_rx88; mem[66] = '0;
    mem[80] = mk(4'd3, 124'd2); mem[81] = mk(4'd3, 124'd2); mem[82] = w_tx1;
    mem[83] = mk(4'd4, '0); mem[84] = mk(4'd4, '0); mem[85] = '0;
    mem[96] = w_rx1234; mem[97] = '0;
    mem[112] = w_tx42; mem[113] = '0;
    mem[1023] = w_tx1;

    repeat (3) tick();
    areset = 1'b0;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_pc", pc, 0);
    chk("rst_addr", bram_porta_addr, 0);
    chk("rst_valids", {tx_tvalid, rx_tvalid}, 0);

    // Basic TX, RX, HALT
    push_tx(w_tx_a); push_rx(w_rx_b);
    pulse_start(0);
    chk("a_busy", busy, 1);
    wait_idle("a");
    chk("a_done", done, 1);
    chk("a_error", error, 0);
    repeat (5) tick();
    chk("a_quiet", {tx_tvalid, rx_tvalid}, 0);
    chk("a_q_empty", exp_q.size(), 0);

    // LOOP 3
    for (int i = 0; i < 3; i++) begin push_tx(w_tx1); push_rx(w_rx2); end
    pulse_start(16);
    wait_idle("loop3");
    chk("loop3_done", done, 1);
    chk("loop3_q_empty", exp_q.size(), 0);

    // LOOP 0 runs body once
    push_tx(w_tx3); push_rx(w_rx4);
    pulse_start(32);
    wait_idle("loop0");
    chk("loop0_done", done, 1);
    chk("loop0_q_empty", exp_q.size(), 0);

    // TX backpressure 50 cycles
    tx_tready = 1'b0;
    push_tx(w_tx55); push_rx(w_rx66);
    pulse_start(48);
    wait_valid("stall", 1'b0);
    d0 = tx_tdata; p0 = pc; stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (!tx_tvalid || tx_tdata !== d0 || pc !== p0 || bram_porta_addr !== p0) stable = 1'b0;
    end
    chk("stall_hold", stable, 1);
    chk("stall_pc", p0, 48);
    tx_tready = 1'b1;
    wait_idle("stall");
    chk("stall_done", done, 1);
    chk("stall_q_empty", exp_q.size(), 0);

    // Stop while EMIT_TX stalled
    tx_tready = 1'b0;
    push_tx(w_tx77);
    pulse_start(64);
    wait_valid("stop", 1'b0);
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (5) tick();
    chk("stop_hold_valid", tx_tvalid, 1);
    chk("stop_hold_busy", busy, 1);
    tx_tready = 1'b1;
    repeat (8) tick();
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    chk("stop_valids", {tx_tvalid, rx_tvalid}, 0);
    chk("stop_q_empty", exp_q.size(), 0);

    // ENDLOOP without LOOP
    pulse_start(5);
    wait_idle("orphan");
    chk("orphan_error", error, 1);
    chk("orphan_done", done, 0);
    repeat (5) tick();
    chk("orphan_quiet", {tx_tvalid, rx_tvalid}, 0);

    // Next start clears error
    push_tx(w_tx_a); push_rx(w_rx_b);
    pulse_start(0);
    chk("restart_error", error, 0);
    wait_idle("restart");
    chk("restart_done", done, 1);
    chk("restart_q_empty", exp_q.size(), 0);

    // Nested LOOP
    pulse_start(80);
    wait_idle("nested");
    chk("nested_error", error, 1);

    // Event at the last address has nowhere to go
    pulse_start(10'd1023);
    wait_idle("end");
    chk("end_error", error, 1);
    chk("end_pc", pc, 1023);

    // Reset during EMIT_RX
    rx_tready = 1'b0;
    pulse_start(96);
    wait_valid("rst_mid", 1'b1);
    areset = 1'b1;
    tick();
    chk("rstmid_valids", {tx_tvalid, rx_tvalid}, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_pc", pc, 0);
    chk("rstmid_flags", {done, error}, 0);
    areset = 1'b0;
    rx_tready = 1'b1;
    repeat (5) tick();
    chk("rstmid_quiet", busy, 0);

    // Start while busy is ignored
    tx_tready = 1'b0;
    push_tx(w_tx42);
    pulse_start(112);
    wait_valid("busy_start", 1'b0);
    pulse_start(0);
    repeat (3) tick();
    chk("busy_start_pc", pc, 112);
    tx_tready = 1'b1;
    wait_idle("busy_start");
    chk("busy_start_done", done, 1);
    chk("busy_start_q_empty", exp_q.size(), 0);

    // Simultaneous start and stop in IDLE
    p0 = pc;
    cfg_start_addr = 0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_busy", busy, 0);
    repeat (10) tick();
    chk("ss_busy_later", busy, 0);
    chk("ss_pc", pc, p0);
    chk("ss_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
